rc4_decryptor: RTL and testbench

RC4 keystream generator and message decryptor (PRGA stage) for the key-cracking datapath, directly downstream of the KSA shuffler. After the shuffler reports finish, this block reuses the same 256x8 S-memory port. It reads the encrypted-message ROM, XORs each byte with the RC4 keystream, and writes the plaintext to the decrypted RAM. While decrypting, it checks that every plaintext byte is lowercase ASCII or space, aborts on the first invalid byte, and reports whether the candidate key passed.

---
 rtl/rc4_pkg.sv | 37 +++
 rtl/rc4_char_check.sv | 15 +
 rtl/rc4_decryptor.sv | 151 +++++++++++++++
 tb/tb_rc4_decryptor.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 PRGA / decryption datapath.
//   - FSM state encoding for rc4_decryptor. The low three bits of every
//     state code are the s_wren, d_wren and finish strobes, so those outputs
//     come straight off state flops. The upper three bits only tell apart
//     states whose strobe bits are equal.
//   - Character-class constants used by rc4_char_check.
//   - Default message length.
package rc4_pkg;

    localparam int MSG_LEN_DEF = 32;

    localparam logic [7:0] CHAR_A  = 8'h61;
    localparam logic [7:0] CHAR_Z  = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    // Bit positions of the strobes embedded in the state code.
    localparam int BIT_S_WREN = 0;
    localparam int BIT_D_WREN = 1;
    localparam int BIT_FINISH = 2;

    // Layout: {id[2:0], finish, d_wren, s_wren}
    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000_000,
        ST_ADDR_I  = 6'b001_000,
        ST_WAIT_I  = 6'b010_000,
        ST_READ_I  = 6'b011_000,
        ST_WAIT_J  = 6'b100_000,
        ST_READ_J  = 6'b101_000,
        ST_WAIT_F  = 6'b110_000,
        ST_READ_F  = 6'b111_000,
        ST_WRITE_J = 6'b000_001,
        ST_WRITE_I = 6'b001_001,
        ST_WRITE_D = 6'b000_010,
        ST_DONE    = 6'b000_100
    } state_t;

endpackage

// File: rtl/rc4_char_check.sv
// rc4_char_check: combinational plaintext character classifier.
// A byte passes when it is a lowercase ASCII letter ('a'..'z') or a space.
// Ports:
//   data  in  8  candidate plaintext byte
//   valid out 1  1 when data is 'a'..'z' or ' '
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] data,
    output logic       valid
);

    assign valid = ((data >= CHAR_A) && (data <= CHAR_Z)) || (data == CHAR_SP);

endmodule

// File: rtl/rc4_decryptor.sv
// rc4_decryptor: RC4 keystream generator (PRGA) and message decryptor.
// Runs after the KSA shuffler on the same single-port 256x8 S-memory.
// For every message byte it advances i/j, swaps S[i]/S[j], looks up the
// keystream byte S[S[i]+S[j]], XORs it with the encrypted ROM byte and writes
// the plaintext to the decrypted RAM. The pass aborts on the first byte that
// is not lowercase ASCII or space; key_valid reports the outcome.
// Ports:
//   clk        in   1       clock
//   reset_n    in   1       asynchronous active-low reset
//   start      in   1       begin a pass (only honoured in IDLE)
//   s_q        in   8       S-memory read data
//   e_q        in   8       encrypted ROM read data
//   s_address  out  8       S-memory address
//   s_data     out  8       S-memory write data
//   s_wren     out  1       S-memory write enable
//   e_address  out  MSG_AW  encrypted ROM address
//   d_address  out  MSG_AW  decrypted RAM address
//   d_data     out  8       decrypted RAM write data
//   d_wren     out  1       decrypted RAM write enable
//   finish     out  1       one-cycle pulse at pass end
//   key_valid  out  1       pass result, held until the next accepted start
module rc4_decryptor
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        s_q,
    input  logic [7:0]        e_q,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    output logic [MSG_AW-1:0] e_address,
    output logic [MSG_AW-1:0] d_address,
    output logic [7:0]        d_data,
    output logic              d_wren,
    output logic              finish,
    output logic              key_valid
);

    localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

    state_t            state;
    logic [7:0]        i;
    logic [7:0]        j;
    logic [7:0]        si;
    logic [7:0]        sj;
    logic [MSG_AW-1:0] k;
    logic              char_ok;

    rc4_char_check u_char_check (
        .data  (d_data),
        .valid (char_ok)
    );

    // Strobes are plain state bits: no decode logic, no glitches.
    assign s_wren = state[BIT_S_WREN];
    assign d_wren = state[BIT_D_WREN];
    assign finish = state[BIT_FINISH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            s_address <= '0;
            s_data    <= '0;
            e_address <= '0;
            d_address <= '0;
            d_data    <= '0;
            key_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    i         <= '0;
                    j         <= '0;
                    k         <= '0;
                    si        <= '0;
                    sj        <= '0;
                    s_address <= '0;
                    s_data    <= '0;
                    e_address <= '0;
                    d_address <= '0;
                    d_data    <= '0;
                    if (start) begin
                        key_valid <= 1'b0;
                        state     <= ST_ADDR_I;
                    end
                end
                ST_ADDR_I: begin
                    i         <= 8'(i + 8'd1);
                    s_address <= 8'(i + 8'd1);
                    e_address <= k;
                    state     <= ST_WAIT_I;
                end
                ST_WAIT_I: state <= ST_READ_I;
                ST_READ_I: begin
                    si        <= s_q;
                    j         <= 8'(j + s_q);
                    s_address <= 8'(j + s_q);
                    state     <= ST_WAIT_J;
                end
                ST_WAIT_J: state <= ST_READ_J;
                ST_READ_J: begin
                    sj     <= s_q;
                    s_data <= si;
                    state  <= ST_WRITE_J;
                end
                // S[j] <= si happens on the edge leaving this state.
                ST_WRITE_J: begin
                    s_address <= i;
                    s_data    <= sj;
                    state     <= ST_WRITE_I;
                end
                // S[i] <= sj; when i==j both writes carry the same value.
                ST_WRITE_I: begin
                    s_address <= 8'(si + sj);
                    state     <= ST_WAIT_F;
                end
                ST_WAIT_F: state <= ST_READ_F;
                ST_READ_F: begin
                    d_data    <= s_q ^ e_q;
                    d_address <= k;
                    state     <= ST_WRITE_D;
                end
                // The byte is written here regardless of its class.
                ST_WRITE_D: begin
                    if (!char_ok) begin
                        key_valid <= 1'b0;
                        state     <= ST_DONE;
                    end else if (k == LAST_K) begin
                        key_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        k     <= k + MSG_AW'(1);
                        state <= ST_ADDR_I;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_decryptor.sv
// Self-checking bench for rc4_decryptor. A software RC4 PRGA over a copy of
// the S-memory predicts every S write, every plaintext write, the abort
// point, key_valid and the finish cycle; a negedge monitor compares the DUT
// against those predictions whenever a write or finish strobe is active.
module tb_rc4_decryptor;

    localparam int MSG_LEN = 32;
    localparam int MSG_AW  = 5;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic [7:0]        s_q     = '0;
    logic [7:0]        e_q     = '0;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [MSG_AW-1:0] e_address;
    logic [MSG_AW-1:0] d_address;
    logic [7:0]        d_data;
    logic              d_wren;
    logic              finish;
    logic              key_valid;

    rc4_decryptor #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .s_q       (s_q),
        .e_q       (e_q),
        .s_address (s_address),
        .s_data    (s_data),
        .s_wren    (s_wren),
        .e_address (e_address),
        .d_address (d_address),
        .d_data    (d_data),
        .d_wren    (d_wren),
        .finish    (finish),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // Memories: synchronous single-port, q registered one edge after the
    // address edge, so the DUT samples it two edges after presenting it.
    logic [7:0] s_mem  [256];
    logic [7:0] s_load [256];
    logic       load_s = 1'b0;
    logic [7:0] e_mem  [2**MSG_AW];
    logic [7:0] d_mem  [2**MSG_AW];

    always @(posedge clk) begin
        if (load_s) s_mem <= s_load;
        else if (s_wren) s_mem[s_address] <= s_data;
        s_q <= s_mem[s_address];
        e_q <= e_mem[e_address];
        if (d_wren) d_mem[d_address] <= d_data;
    end

    int errs = 0;
    int chks = 0;
    int edge_cnt = 0;
    int t0 = 0;
    int fin_cnt = 0;
    int fin_cyc = 0;
    int max_e = 0;
    bit chk_en = 1'b0;

    logic [15:0] exp_sw[$];
    logic [15:0] exp_d[$];
    logic [7:0]  exp_s  [256];
    logic [7:0]  exp_pt [MSG_LEN];
    logic [7:0]  gen_pt [MSG_LEN];
    int          exp_n;
    logic        exp_kv;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic bit is_text(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7a)) || (c == 8'h20);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        chks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] w;
        if (chk_en) begin
            if (s_wren) begin
                if (exp_sw.size() == 0) check("s_write_extra", {16'b0, s_address, s_data}, 32'hffffffff);
                else begin
                    w = exp_sw.pop_front();
                    check("s_write", {16'b0, s_address, s_data}, {16'b0, w});
                end
            end
            if (d_wren) begin
                if (exp_d.size() == 0) check("d_write_extra", {16'b0, 8'(d_address), d_data}, 32'hffffffff);
                else begin
                    w = exp_d.pop_front();
                    check("d_write", {16'b0, 8'(d_address), d_data}, {16'b0, w});
                end
            end
            if (int'(e_address) > max_e) max_e = int'(e_address);
            if (finish) begin
                fin_cnt++;
                fin_cyc = edge_cnt - t0 + 1;
                check("key_valid_at_finish", 32'(key_valid), 32'(exp_kv));
            end
        end
    end

    // Software RC4 PRGA over the current S-memory and ROM contents.
    task automatic model_run();
        logic [7:0] ms [256];
        logic [7:0] mi, mj, a, b, f, p;
        for (int x = 0; x < 256; x++) ms[x] = s_mem[x];
        mi = 0; mj = 0;
        exp_sw.delete();
        exp_d.delete();
        exp_n  = MSG_LEN - 1;
        exp_kv = 1'b1;
        for (int k = 0; k < MSG_LEN; k++) begin
            mi = mi + 8'd1;
            a  = ms[mi];
            mj = mj + a;
            b  = ms[mj];
            ms[mj] = a;
            ms[mi] = b;
            exp_sw.push_back({mj, a});
            exp_sw.push_back({mi, b});
            f = ms[8'(a + b)];
            p = e_mem[k] ^ f;
            exp_pt[k] = p;
            exp_d.push_back({8'(k), p});
            if (!is_text(p)) begin
                exp_n  = k;
                exp_kv = 1'b0;
                break;
            end
        end
        for (int x = 0; x < 256; x++) exp_s[x] = ms[x];
    endtask

    task automatic load_smem();
        load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
    endtask

    task automatic preload_identity();
        for (int x = 0; x < 256; x++) s_load[x] = 8'(x);
        load_smem();
    endtask

    task automatic preload_perm();
        logic [7:0] t;
        int r;
        for (int x = 0; x < 256; x++) s_load[x] = 8'(x);
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = s_load[x]; s_load[x] = s_load[r]; s_load[r] = t;
        end
        load_smem();
    endtask

    task automatic preload_ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] key [3];
        logic [7:0] kj, t;
        key[0] = k0; key[1] = k1; key[2] = k2;
        for (int x = 0; x < 256; x++) s_load[x] = 8'(x);
        kj = 0;
        for (int x = 0; x < 256; x++) begin
            kj = kj + s_load[x] + key[x % 3];
            t = s_load[x]; s_load[x] = s_load[kj]; s_load[kj] = t;
        end
        load_smem();
    endtask

    // Random lowercase/space plaintext, optionally one control byte at bad_pos,
    // encrypted with the keystream the current S-memory will produce.
    task automatic gen_enc(input bit bad, input int bad_pos);
        logic [7:0] ms [256];
        logic [7:0] mi, mj, a, b;
        int r;
        for (int k = 0; k < MSG_LEN; k++) begin
            r = $urandom_range(26, 0);
            gen_pt[k] = (r == 26) ? 8'h20 : 8'h61 + 8'(r);
        end
        if (bad) gen_pt[bad_pos] = 8'($urandom_range(31, 0));
        for (int x = 0; x < 256; x++) ms[x] = s_mem[x];
        mi = 0; mj = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            mi = mi + 8'd1;
            a  = ms[mi];
            mj = mj + a;
            b  = ms[mj];
            ms[mj] = a;
            ms[mi] = b;
            e_mem[k] = gen_pt[k] ^ ms[8'(a + b)];
        end
    endtask

    task automatic run_pass(input bit poke);
        int c;
        int bad;
        model_run();
        max_e   = 0;
        fin_cnt = 0;
        chk_en  = 1'b1;
        start   = 1'b1;
        t0      = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (fin_cnt == 0 && c < 400) begin
            start = poke && (c == 25);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        if (fin_cnt == 0) begin
            check("finish_timeout", 32'd0, 32'd1);
            chk_en = 1'b0;
            return;
        end
        @(negedge clk);
        chk_en = 1'b0;
        check("finish_one_cycle", 32'(finish), 32'd0);
        check("finish_pulse_count", 32'(fin_cnt), 32'd1);
        check("key_valid_held", 32'(key_valid), 32'(exp_kv));
        check("finish_cycle", 32'(fin_cyc), 32'(10 * (exp_n + 1) + 1));
        check("max_e_address", 32'(max_e), 32'(exp_n));
        check("s_writes_left", 32'(exp_sw.size()), 32'd0);
        check("d_writes_left", 32'(exp_d.size()), 32'd0);
        bad = 0;
        for (int k = 0; k <= exp_n; k++) if (d_mem[k] !== exp_pt[k]) bad++;
        check("d_mem_contents", 32'(bad), 32'd0);
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== exp_s[x]) bad++;
        check("s_mem_contents", 32'(bad), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {s_address, s_data, 3'b0, e_address, 3'b0, d_address},  32'd0);
        check({name, "_ctl"}, {d_data, 20'b0, s_wren, d_wren, finish, key_valid}, 32'd0);
    endtask

    initial begin
        int bad;
        int c;

        // Reset state.
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_outputs");
        reset_n = 1'b1;
        @(negedge clk);

        // Identity S, three bytes: 'a', 'b', then 'A' aborts.
        for (int k = 0; k < MSG_LEN; k++) e_mem[k] = 8'h00;
        e_mem[0] = 8'h63;
        e_mem[1] = 8'h67;
        e_mem[2] = 8'h46;
        preload_identity();
        model_run();
        check("model_pt0", 32'(exp_pt[0]), 32'h61);
        check("model_pt1", 32'(exp_pt[1]), 32'h62);
        check("model_pt2", 32'(exp_pt[2]), 32'h41);
        check("model_n", 32'(exp_n), 32'd2);
        check("model_s", {exp_s[1], exp_s[2], exp_s[3], exp_s[5]}, 32'h01_03_05_02);
        run_pass(1'b0);
        check("ident_finish_cycle", 32'(fin_cyc), 32'd31);
        check("ident_key_valid", 32'(key_valid), 32'd0);
        check("ident_d_mem", {8'h00, d_mem[0], d_mem[1], d_mem[2]}, 32'h00_61_62_41);
        check("ident_no_rom_3", 32'(max_e), 32'd2);

        // Full valid pass after KSA with key 00 02 49; start poked mid-pass.
        preload_ksa(8'h00, 8'h02, 8'h49);
        gen_enc(1'b0, 0);
        run_pass(1'b1);
        bad = 0;
        for (int k = 0; k < MSG_LEN; k++) if (exp_pt[k] !== gen_pt[k]) bad++;
        check("model_matches_plaintext", 32'(bad), 32'd0);
        check("full_finish_cycle", 32'(fin_cyc), 32'd321);
        check("full_key_valid", 32'(key_valid), 32'd1);

        // Second start after finish: fresh i=j=k=0 on the updated S.
        gen_enc(1'b0, 0);
        run_pass(1'b0);

        // Reset asserted during WRITE_J (first S write strobe).
        gen_enc(1'b0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!s_wren && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("reset_test_saw_wren", 32'(s_wren), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midpass_reset");
        reset_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (s_wren || d_wren || finish) bad++;
        end
        check("after_reset_quiet", 32'(bad), 32'd0);

        // Randomized passes on random permutations, some with a bad byte.
        for (int p = 0; p < 8; p++) begin
            if (p != 3) preload_perm();
            gen_enc(($urandom_range(1, 0) == 1), $urandom_range(MSG_LEN - 1, 0));
            if (p == 6) for (int k = 0; k < MSG_LEN; k++) e_mem[k] = 8'($urandom_range(255, 0));
            run_pass(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
